// File: rtl/instr_register_pkg.sv
// Shared types for the pipelined instruction register: opcode encoding and
// the lowest opcode value that is treated as illegal.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  localparam logic [3:0] ILLEGAL_OPC_MIN = 4'd8;

endpackage

// File: rtl/instr_alu.sv
// Combinational instruction ALU: double-width signed result plus an error flag
// for divide/modulo by zero and for illegal opcodes.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = 32
) (
  input  opcode_t                        opcode,
  input  logic signed [OP_WIDTH-1:0]     a,
  input  logic signed [OP_WIDTH-1:0]     b,
  output logic signed [2*OP_WIDTH-1:0]   result,
  output logic                           err
);

  localparam int RW = 2 * OP_WIDTH;

  logic signed [RW-1:0] ax;
  logic signed [RW-1:0] bx;

  // Widening first makes MULT exact and keeps (most-negative / -1) representable.
  assign ax = RW'(a);
  assign bx = RW'(b);

  always_comb begin
    result = '0;
    err    = 1'b0;
    if (opcode >= ILLEGAL_OPC_MIN) begin
      err = 1'b1;
    end else begin
      case (opcode)
        ZERO:  result = '0;
        PASSA: result = ax;
        PASSB: result = bx;
        ADD:   result = ax + bx;
        SUB:   result = ax - bx;
        MULT:  result = ax * bx;
        DIV: begin
          if (b == '0) err = 1'b1;
          else         result = ax / bx;
        end
        MOD: begin
          if (b == '0) err = 1'b1;
          else         result = ax % bx;
        end
        default: err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/instr_register_calc.sv
// Pipelined instruction register: S1 captures the instruction and computes its
// result, the next edge commits it; reads are registered with S1 forwarding.
module instr_register_calc
  import instr_register_pkg::*;
#(
  parameter  int DEPTH    = 32,
  parameter  int OP_WIDTH = 32,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [AW-1:0]                 write_pointer,
  input  opcode_t                       opcode,
  input  logic signed [OP_WIDTH-1:0]    operand_a,
  input  logic signed [OP_WIDTH-1:0]    operand_b,
  input  logic [AW-1:0]                 read_pointer,
  output opcode_t                       rd_opcode,
  output logic signed [OP_WIDTH-1:0]    rd_op_a,
  output logic signed [OP_WIDTH-1:0]    rd_op_b,
  output logic signed [2*OP_WIDTH-1:0]  rd_result,
  output logic                          rd_valid,
  output logic                          rd_err,
  output logic [AW:0]                   entry_count
);

  localparam int RW = 2 * OP_WIDTH;

  logic                       vld_p1;
  logic [AW-1:0]              addr_p1;
  opcode_t                    opc_p1;
  logic signed [OP_WIDTH-1:0] a_p1;
  logic signed [OP_WIDTH-1:0] b_p1;
  logic signed [RW-1:0]       res_p1;
  logic                       err_p1;

  opcode_t                    mem_opc [DEPTH];
  logic signed [OP_WIDTH-1:0] mem_a   [DEPTH];
  logic signed [OP_WIDTH-1:0] mem_b   [DEPTH];
  logic signed [RW-1:0]       mem_res [DEPTH];
  logic [DEPTH-1:0]           mem_err;
  logic [DEPTH-1:0]           valid;

  // ---- S1: capture instruction; result is computed from these registers ----
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= load_en;
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      addr_p1 <= write_pointer;
      opc_p1  <= opcode;
      a_p1    <= operand_a;
      b_p1    <= operand_b;
    end
  end

  instr_alu #(
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .opcode (opc_p1),
    .a      (a_p1),
    .b      (b_p1),
    .result (res_p1),
    .err    (err_p1)
  );

  // ---- Commit: S1 contents written to storage ----
  always_ff @(posedge clk) begin
    if (vld_p1 && !reset) begin
      mem_opc[addr_p1] <= opc_p1;
      mem_a[addr_p1]   <= a_p1;
      mem_b[addr_p1]   <= b_p1;
      mem_res[addr_p1] <= res_p1;
      mem_err[addr_p1] <= err_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= '0;
      entry_count <= '0;
    end else if (vld_p1) begin
      valid[addr_p1] <= 1'b1;
      if (!valid[addr_p1]) entry_count <= entry_count + {{AW{1'b0}}, 1'b1};
    end
  end

  // ---- Read register: forward the committing S1 entry ahead of storage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_opcode <= ZERO;
      rd_op_a   <= '0;
      rd_op_b   <= '0;
      rd_result <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
    end else if (vld_p1 && (addr_p1 == read_pointer)) begin
      rd_opcode <= opc_p1;
      rd_op_a   <= a_p1;
      rd_op_b   <= b_p1;
      rd_result <= res_p1;
      rd_valid  <= 1'b1;
      rd_err    <= err_p1;
    end else if (valid[read_pointer]) begin
      rd_opcode <= mem_opc[read_pointer];
      rd_op_a   <= mem_a[read_pointer];
      rd_op_b   <= mem_b[read_pointer];
      rd_result <= mem_res[read_pointer];
      rd_valid  <= 1'b1;
      rd_err    <= mem_err[read_pointer];
    end else begin
      rd_opcode <= ZERO;
      rd_op_a   <= '0;
      rd_op_b   <= '0;
      rd_result <= '0;
      rd_valid  <= 1'b0;
      rd_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_register_calc.sv
// Bench for instr_register_calc: directed scenarios plus randomized traffic
// checked against an edge-level behavioural model of the register file.
module tb_instr_register_calc;
  import instr_register_pkg::*;

  localparam int DEPTH = 32;
  localparam int OPW   = 32;
  localparam int AW    = $clog2(DEPTH);

  logic                   clk;
  logic                   reset;
  logic                   load_en;
  logic [AW-1:0]          write_pointer;
  opcode_t                opcode;
  logic signed [OPW-1:0]  operand_a;
  logic signed [OPW-1:0]  operand_b;
  logic [AW-1:0]          read_pointer;
  opcode_t                rd_opcode;
  logic signed [OPW-1:0]  rd_op_a;
  logic signed [OPW-1:0]  rd_op_b;
  logic signed [2*OPW-1:0] rd_result;
  logic                   rd_valid;
  logic                   rd_err;
  logic [AW:0]            entry_count;

  instr_register_calc #(
    .DEPTH    (DEPTH),
    .OP_WIDTH (OPW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .write_pointer (write_pointer),
    .opcode        (opcode),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .read_pointer  (read_pointer),
    .rd_opcode     (rd_opcode),
    .rd_op_a       (rd_op_a),
    .rd_op_b       (rd_op_b),
    .rd_result     (rd_result),
    .rd_valid      (rd_valid),
    .rd_err        (rd_err),
    .entry_count   (entry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: a write at edge t becomes visible to reads sampled at edge t+1 on.
  logic [3:0] m_opc   [DEPTH];
  longint     m_a     [DEPTH];
  longint     m_b     [DEPTH];
  longint     m_res   [DEPTH];
  bit         m_err   [DEPTH];
  bit         m_valid [DEPTH];

  logic [3:0]          e_opc;
  logic signed [31:0]  e_a;
  logic signed [31:0]  e_b;
  logic signed [63:0]  e_res;
  logic                e_valid;
  logic                e_err;
  int                  e_count;

  function automatic void ref_calc(input int opc, input longint a, input longint b,
                                   output longint r, output bit er);
    r  = 0;
    er = 1'b0;
    case (opc)
      0: r = 0;
      1: r = a;
      2: r = b;
      3: r = a + b;
      4: r = a - b;
      5: r = a * b;
      6: if (b == 0) er = 1'b1; else r = a / b;
      7: if (b == 0) er = 1'b1; else r = a % b;
      default: er = 1'b1;
    endcase
  endfunction

  task automatic tick(input bit rst, input bit ld, input int wp, input int opc,
                      input logic signed [31:0] a, input logic signed [31:0] b, input int rp);
    longint r;
    bit     er;
    reset         = rst;
    load_en       = ld;
    write_pointer = wp[AW-1:0];
    opcode        = opcode_t'(opc[3:0]);
    operand_a     = a;
    operand_b     = b;
    read_pointer  = rp[AW-1:0];
    @(posedge clk);
    if (rst) begin
      e_opc = '0; e_a = '0; e_b = '0; e_res = '0; e_valid = 1'b0; e_err = 1'b0;
      e_count = 0;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else begin
      if (m_valid[rp]) begin
        e_opc = m_opc[rp]; e_a = 32'(m_a[rp]); e_b = 32'(m_b[rp]);
        e_res = m_res[rp]; e_valid = 1'b1; e_err = m_err[rp];
      end else begin
        e_opc = '0; e_a = '0; e_b = '0; e_res = '0; e_valid = 1'b0; e_err = 1'b0;
      end
      e_count = 0;
      foreach (m_valid[i]) e_count += int'(m_valid[i]);
      if (ld) begin
        ref_calc(opc, longint'(a), longint'(b), r, er);
        m_opc[wp] = opc[3:0]; m_a[wp] = longint'(a); m_b[wp] = longint'(b);
        m_res[wp] = r; m_err[wp] = er; m_valid[wp] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 0, 0, 0, 0, 0);
    vectors++;
    if ({rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result, entry_count} !== '0) begin
      $display("FAIL reset_edge got=%h exp=0",
               {rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result, entry_count});
      miscompares++;
    end
    for (int rp = 0; rp < DEPTH; rp++) begin
      tick(1'b0, 1'b0, 0, 0, 0, 0, rp);
      vectors++;
      if ({rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result, entry_count} !== '0) begin
        $display("FAIL reset_read[%0d] got=%h exp=0", rp,
                 {rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result, entry_count});
        miscompares++;
      end
    end
  endtask

  task automatic test_add();
    tick(1'b0, 1'b1, 3, 3, -32'sd5, 32'sd7, 0);
    tick(1'b0, 1'b0, 0, 0, 0, 0, 0);
    tick(1'b0, 1'b0, 0, 0, 0, 0, 3);
    vectors++;
    if (rd_result !== 64'sd2) begin
      $display("FAIL add_result got=%0d exp=2", rd_result); miscompares++;
    end
    vectors++;
    if ({rd_valid, rd_err} !== 2'b10) begin
      $display("FAIL add_flags got=%b exp=10", {rd_valid, rd_err}); miscompares++;
    end
    vectors++;
    if (rd_opcode !== ADD || rd_op_a !== -32'sd5 || rd_op_b !== 32'sd7) begin
      $display("FAIL add_fields got=%0d/%0d/%0d exp=3/-5/7", rd_opcode, rd_op_a, rd_op_b);
      miscompares++;
    end
    vectors++;
    if (entry_count !== 6'd1) begin
      $display("FAIL add_count got=%0d exp=1", entry_count); miscompares++;
    end
  endtask

  task automatic test_alu_corners();
    int                 c_opc [7] = '{5, 6, 7, 6, 7, 12, 6};
    logic signed [31:0] c_a   [7] = '{32'sh7FFFFFFF, -32'sd7, -32'sd7, 32'sd9, 32'sd5, 32'sd3, 32'sh80000000};
    logic signed [31:0] c_b   [7] = '{32'sd2, 32'sd2, 32'sd2, 32'sd0, 32'sd0, 32'sd4, -32'sd1};
    logic signed [63:0] c_res [7] = '{64'sh00000000FFFFFFFE, -64'sd3, -64'sd1, 64'sd0, 64'sd0, 64'sd0,
                                      64'sh0000000080000000};
    logic               c_err [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1, 10 + i, c_opc[i], c_a[i], c_b[i], 0);
      tick(1'b0, 1'b0, 0, 0, 0, 0, 0);
      tick(1'b0, 1'b0, 0, 0, 0, 0, 10 + i);
      vectors++;
      if (rd_result !== c_res[i] || rd_err !== c_err[i] || rd_valid !== 1'b1) begin
        $display("FAIL alu_case[%0d] got res=%h err=%b vld=%b exp res=%h err=%b vld=1",
                 i, rd_result, rd_err, rd_valid, c_res[i], c_err[i]);
        miscompares++;
      end
    end
    vectors++;
    if (entry_count !== 6'd8) begin
      $display("FAIL alu_count got=%0d exp=8", entry_count); miscompares++;
    end
  endtask

  task automatic test_forward();
    tick(1'b0, 1'b1, 5, 3, 32'sd100, 32'sd20, 5);
    vectors++;
    if (rd_valid !== 1'b0 || rd_result !== 64'sd0) begin
      $display("FAIL fwd_same_edge got vld=%b res=%0d exp vld=0 res=0", rd_valid, rd_result);
      miscompares++;
    end
    tick(1'b0, 1'b0, 0, 0, 0, 0, 5);
    vectors++;
    if (rd_valid !== 1'b1 || rd_result !== 64'sd120 || rd_opcode !== ADD || rd_op_a !== 32'sd100) begin
      $display("FAIL fwd_next_edge got vld=%b res=%0d opc=%0d a=%0d exp vld=1 res=120 opc=3 a=100",
               rd_valid, rd_result, rd_opcode, rd_op_a);
      miscompares++;
    end
    vectors++;
    if (entry_count !== 6'd9) begin
      $display("FAIL fwd_count got=%0d exp=9", entry_count); miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b0, 1'b1, 6, 4, 32'sd50, 32'sd8, 6);
    tick(1'b0, 1'b1, 6, 5, -32'sd3, 32'sd4, 0);
    tick(1'b0, 1'b0, 0, 0, 0, 0, 6);
    vectors++;
    if (rd_result !== -64'sd12 || rd_opcode !== MULT) begin
      $display("FAIL b2b_forward got res=%0d opc=%0d exp res=-12 opc=5", rd_result, rd_opcode);
      miscompares++;
    end
    tick(1'b0, 1'b0, 0, 0, 0, 0, 6);
    vectors++;
    if (rd_result !== -64'sd12 || rd_op_a !== -32'sd3 || rd_valid !== 1'b1) begin
      $display("FAIL b2b_stored got res=%0d a=%0d vld=%b exp res=-12 a=-3 vld=1",
               rd_result, rd_op_a, rd_valid);
      miscompares++;
    end
    vectors++;
    if (entry_count !== 6'd10) begin
      $display("FAIL b2b_count got=%0d exp=10", entry_count); miscompares++;
    end
  endtask

  task automatic test_reset_pending();
    tick(1'b0, 1'b1, 2, 3, 32'sd1, 32'sd1, 0);
    tick(1'b1, 1'b0, 0, 0, 0, 0, 2);
    tick(1'b0, 1'b0, 0, 0, 0, 0, 2);
    vectors++;
    if (rd_valid !== 1'b0 || rd_result !== 64'sd0 || entry_count !== 6'd0) begin
      $display("FAIL rst_pending got vld=%b res=%0d cnt=%0d exp vld=0 res=0 cnt=0",
               rd_valid, rd_result, entry_count);
      miscompares++;
    end
    tick(1'b1, 1'b1, 7, 1, 32'sd9, 32'sd0, 0);
    tick(1'b0, 1'b0, 0, 0, 0, 0, 7);
    tick(1'b0, 1'b0, 0, 0, 0, 0, 7);
    vectors++;
    if (rd_valid !== 1'b0 || rd_op_a !== 32'sd0 || entry_count !== 6'd0) begin
      $display("FAIL rst_with_load got vld=%b a=%0d cnt=%0d exp vld=0 a=0 cnt=0",
               rd_valid, rd_op_a, entry_count);
      miscompares++;
    end
  endtask

  task automatic test_random();
    int last_wp = 0;
    for (int n = 0; n < 800; n++) begin
      bit rst = ($urandom_range(0, 99) == 0);
      bit ld  = ($urandom_range(0, 3) != 0);
      int wp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                            : int'($urandom_range(0, 7));
      int opc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15))
                                            : int'($urandom_range(0, 7));
      logic signed [31:0] a = $urandom;
      logic signed [31:0] b;
      int rp;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = 32'($signed($urandom_range(0, 20)) - 10);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 0) a = 32'($signed($urandom_range(0, 200)) - 100);
      rp = ($urandom_range(0, 1) == 0) ? last_wp : int'($urandom_range(0, 7));
      tick(rst, ld, wp, opc, a, b, rp);
      if (ld && !rst) last_wp = wp;
      vectors++;
      if ({rd_valid, rd_err, 4'(rd_opcode), rd_op_a, rd_op_b, rd_result} !==
          {e_valid, e_err, e_opc, e_a, e_b, e_res}) begin
        $display("FAIL rand_read[%0d] rp=%0d got vld=%b err=%b opc=%0d a=%h b=%h res=%h exp vld=%b err=%b opc=%0d a=%h b=%h res=%h",
                 n, rp, rd_valid, rd_err, rd_opcode, rd_op_a, rd_op_b, rd_result,
                 e_valid, e_err, e_opc, e_a, e_b, e_res);
        miscompares++;
      end
      vectors++;
      if (int'(entry_count) != e_count) begin
        $display("FAIL rand_count[%0d] got=%0d exp=%0d", n, entry_count, e_count);
        miscompares++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; write_pointer = '0; opcode = ZERO;
    operand_a = '0; operand_b = '0; read_pointer = '0;
    test_reset();
    test_add();
    test_alu_corners();
    test_forward();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
